// File: rtl/fifo_mr_act_v2.sv
// Single-write, multi-read activation FIFO: one shared store, per-reader pointer and occupancy.
// Build option FIFO_MR_ACT_FWFT_EN selects first-word fall-through reads; default is a registered 1-cycle read.
module fifo_mr_act_v2 #(
   parameter int DATA_WIDTH   = 64,
   parameter int ADDR_WIDTH   = 4,
   parameter int RAM_DEPTH    = 1 << ADDR_WIDTH,
   parameter int RD_NUM       = 3,
   parameter int AFULL_THRESH = RAM_DEPTH - 2
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               clr,
   input  logic [RD_NUM-1:0]                  rd_active,
   input  logic                               push,
   input  logic [DATA_WIDTH-1:0]              data_in,
   output logic                               full,
   output logic                               almost_full,
   input  logic [RD_NUM-1:0]                  pop,
   output logic [DATA_WIDTH*RD_NUM-1:0]       data_out,
   output logic [RD_NUM-1:0]                  data_valid,
   output logic [RD_NUM-1:0]                  empty,
   output logic [(ADDR_WIDTH+1)*RD_NUM-1:0]   count,
   output logic                               ovf_err,
   output logic [RD_NUM-1:0]                  udf_err
);
   localparam int CW = ADDR_WIDTH + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(RAM_DEPTH);
   localparam logic [CW-1:0] AFULL_C = CW'(AFULL_THRESH);

   logic [DATA_WIDTH-1:0]                mem_q [RAM_DEPTH];
   logic [ADDR_WIDTH-1:0]                wr_ptr_q, wr_ptr_d;
   logic [RD_NUM-1:0][ADDR_WIDTH-1:0]    rd_ptr_q, rd_ptr_d;
   logic [RD_NUM-1:0][CW-1:0]            cnt_q, cnt_d;
   logic                                 ovf_q, ovf_d;
   logic [RD_NUM-1:0]                    udf_q, udf_d;
   logic [RD_NUM-1:0]                    full_v, afull_v, rd_ok;
   logic [RD_NUM-1:0][DATA_WIDTH-1:0]    rd_word;
   logic                                 wr_ok;

   // Flags look only at active readers so an idle reader never back-pressures the writer.
   always_comb begin
      full_v  = '0;
      afull_v = '0;
      empty   = '0;
      rd_word = '0;
      for (int i = 0; i < RD_NUM; i++) begin
         full_v[i]  = rd_active[i] && (cnt_q[i] == DEPTH_C);
         afull_v[i] = rd_active[i] && (cnt_q[i] >= AFULL_C);
         empty[i]   = (cnt_q[i] == '0) || !rd_active[i];
         rd_word[i] = mem_q[rd_ptr_q[i]];
      end
   end

   assign full        = |full_v;
   assign almost_full = |afull_v;
   assign wr_ok       = push & ~full;
   assign rd_ok       = pop & rd_active & ~empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(wr_ok);
      ovf_d    = ovf_q | (push & full);
      udf_d    = udf_q | (pop & empty);
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      for (int i = 0; i < RD_NUM; i++) begin
         // An idle reader tracks the write pointer so activation starts at the next word written.
         if (!rd_active[i]) begin
            rd_ptr_d[i] = wr_ptr_d;
            cnt_d[i]    = '0;
         end else begin
            rd_ptr_d[i] = rd_ptr_q[i] + ADDR_WIDTH'(rd_ok[i]);
            cnt_d[i]    = cnt_q[i] + CW'(wr_ok) - CW'(rd_ok[i]);
         end
      end
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
         ovf_d    = 1'b0;
         udf_d    = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok && !clr) mem_q[wr_ptr_q] <= data_in;
   end

   assign count   = cnt_q;
   assign ovf_err = ovf_q;
   assign udf_err = udf_q;

`ifdef FIFO_MR_ACT_FWFT_EN
   logic [RD_NUM-1:0][DATA_WIDTH-1:0] dout_c;

   always_comb begin
      dout_c = '0;
      for (int i = 0; i < RD_NUM; i++)
         if (!empty[i]) dout_c[i] = rd_word[i];
   end

   assign data_out   = dout_c;
   assign data_valid = ~empty;
`else
   logic [RD_NUM-1:0][DATA_WIDTH-1:0] dout_q, dout_d;
   logic [RD_NUM-1:0]                 dval_q, dval_d;

   always_comb begin
      dout_d = dout_q;
      dval_d = rd_ok;
      for (int i = 0; i < RD_NUM; i++)
         if (rd_ok[i]) dout_d[i] = rd_word[i];
      if (clr) begin
         dout_d = '0;
         dval_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout_q <= '0;
         dval_q <= '0;
      end else begin
         dout_q <= dout_d;
         dval_q <= dval_d;
      end
   end

   assign data_out   = dout_q;
   assign data_valid = dval_q;
`endif

endmodule

// File: tb/tb_fifo_mr_act_v2.sv
// Directed bench for fifo_mr_act_v2 with a per-reader queue model checked every cycle.
module tb_fifo_mr_act_v2;
   localparam int DW = 16;
   localparam int AW = 4;
   localparam int DEPTH = 16;
   localparam int RN = 3;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              clr, push;
   logic [RN-1:0]     act, pop;
   logic [DW-1:0]     din;
   logic              full, almost_full, ovf_err;
   logic [DW*RN-1:0]  data_out;
   logic [RN-1:0]     data_valid, empty, udf_err;
   logic [(AW+1)*RN-1:0] count;

   int n_checks = 0;
   int n_fail   = 0;

   fifo_mr_act_v2 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH), .RD_NUM(RN),
                    .AFULL_THRESH(14)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .rd_active(act), .push(push), .data_in(din),
      .full(full), .almost_full(almost_full), .pop(pop), .data_out(data_out),
      .data_valid(data_valid), .empty(empty), .count(count), .ovf_err(ovf_err),
      .udf_err(udf_err));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
      n_checks++;
      if (a !== e) begin
         n_fail++;
         if (n_fail <= 40) $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, a, e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model: each reader is a queue of the words it still has to read.
   logic [DW-1:0]         q [RN][$];
   logic [RN-1:0][DW-1:0] m_dout = '0;
   logic [RN-1:0]         m_dval = '0;
   logic                  m_ovf  = 1'b0;
   logic [RN-1:0]         m_udf  = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n || clr) begin
         for (int i = 0; i < RN; i++) q[i].delete();
         m_dout = '0;
         m_dval = '0;
         m_ovf  = 1'b0;
         m_udf  = '0;
      end else begin
         bit f;
         bit w;
         f = 1'b0;
         for (int i = 0; i < RN; i++) if (act[i] && q[i].size() == DEPTH) f = 1'b1;
         w = push && !f;
         if (push && f) m_ovf = 1'b1;
         for (int i = 0; i < RN; i++) begin
            m_dval[i] = 1'b0;
            if (!act[i]) begin
               if (pop[i]) m_udf[i] = 1'b1;
               q[i].delete();
            end else begin
               if (pop[i]) begin
                  if (q[i].size() == 0) m_udf[i] = 1'b1;
                  else begin
                     m_dout[i] = q[i].pop_front();
                     m_dval[i] = 1'b1;
                  end
               end
               if (w) q[i].push_back(din);
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [RN-1:0]         e_empty;
      logic [RN-1:0][AW:0]   e_cnt;
      logic [RN-1:0][DW-1:0] e_dout;
      logic [RN-1:0]         e_dval;
      logic                  e_full, e_af;
      e_full = 1'b0;
      e_af   = 1'b0;
      for (int i = 0; i < RN; i++) begin
         e_cnt[i]   = (AW+1)'(q[i].size());
         e_empty[i] = (q[i].size() == 0) || !act[i];
         if (act[i] && q[i].size() == DEPTH) e_full = 1'b1;
         if (act[i] && q[i].size() >= 14)    e_af   = 1'b1;
`ifdef FIFO_MR_ACT_FWFT_EN
         e_dout[i] = e_empty[i] ? '0 : q[i][0];
         e_dval[i] = !e_empty[i];
`else
         e_dout[i] = m_dout[i];
         e_dval[i] = m_dval[i];
`endif
      end
      chk("cyc_full", full, e_full);
      chk("cyc_afull", almost_full, e_af);
      chk("cyc_empty", empty, e_empty);
      chk("cyc_count", count, e_cnt);
      chk("cyc_dout", data_out, e_dout);
      chk("cyc_dval", data_valid, e_dval);
      chk("cyc_ovf", ovf_err, m_ovf);
      chk("cyc_udf", udf_err, m_udf);
   end

   initial begin
      logic [DW-1:0] e;
      clr = 1'b0; push = 1'b0; pop = '0; din = '0; act = 3'b111;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("rst_empty", empty, 3'b111);
      chk("rst_cnt", count, 0);
      chk("rst_flags", {full, almost_full, ovf_err, udf_err}, 0);
      chk("rst_dout", data_out, 0);

      // fill, then overflow attempt
      for (int k = 0; k < 17; k++) begin
         push = 1'b1;
         din  = (k == 16) ? 16'h00FF : 16'(k);
         tick();
         if (k == 12) chk("afull_13", almost_full, 0);
         if (k == 13) chk("afull_14", almost_full, 1);
         if (k == 14) chk("full_15", full, 0);
         if (k == 15) chk("full_16", full, 1);
         if (k == 16) begin
            chk("ovf_17", ovf_err, 1);
            chk("cnt_17", count, {3{5'd16}});
         end
      end
      push = 1'b0;
      pop  = 3'b111;
      for (int k = 0; k < 16; k++) begin
         e = 16'(k);
`ifdef FIFO_MR_ACT_FWFT_EN
         chk("drain_data", data_out, {3{e}});
         tick();
`else
         tick();
         chk("drain_data", data_out, {3{e}});
         chk("drain_dv", data_valid, 3'b111);
`endif
      end
      pop = '0;
      chk("drain_empty", empty, 3'b111);
      chk("drain_ovf_sticky", ovf_err, 1);
      clr = 1'b1; tick(); clr = 1'b0;
      chk("clr_ovf", ovf_err, 0);

      // independent readers
      push = 1'b1;
      for (int k = 0; k < 8; k++) begin din = 16'h0100 + 16'(k); tick(); end
      push = 1'b0;
      for (int k = 0; k < 8; k++) begin pop = {1'b0, k < 3, 1'b1}; tick(); end
      pop = '0;
      chk("indep_cnt", count, {5'd8, 5'd5, 5'd0});
      push = 1'b1;
      for (int k = 0; k < 8; k++) begin din = 16'h0108 + 16'(k); tick(); end
      push = 1'b0;
      chk("indep_full", full, 1);
      chk("indep_cnt2", count, {5'd16, 5'd13, 5'd8});
      pop = 3'b100; tick(); pop = '0;
      chk("indep_unfull", full, 0);

      // simultaneous push/pop at full and at empty
      clr = 1'b1; tick(); clr = 1'b0;
      push = 1'b1;
      for (int k = 0; k < 16; k++) begin din = 16'h0200 + 16'(k); tick(); end
      push = 1'b0;
      pop = 3'b101; repeat (16) tick(); pop = '0;
      chk("sim_pre", count, {5'd0, 5'd16, 5'd0});
      push = 1'b1; din = 16'h0EEE; pop = 3'b010;
`ifdef FIFO_MR_ACT_FWFT_EN
      chk("sim_oldest", data_out[31:16], 16'h0200);
      tick();
`else
      tick();
      chk("sim_oldest", data_out[31:16], 16'h0200);
`endif
      chk("sim_full_cnt", count[9:5], 15);
      chk("sim_ovf", ovf_err, 1);
      din = 16'h0EEF; pop = 3'b001; tick(); push = 1'b0; pop = '0;
      chk("sim_empty_cnt", count, {5'd1, 5'd16, 5'd1});
      chk("sim_udf", udf_err, 3'b001);

      // wrap-around streaming
      clr = 1'b1; tick(); clr = 1'b0;
      for (int k = 0; k <= 40; k++) begin
         push = (k < 40);
         din  = 16'h0300 + 16'(k);
         pop  = (k > 0) ? 3'b111 : 3'b000;
         e    = 16'h0300 + 16'(k) - 16'd1;
`ifdef FIFO_MR_ACT_FWFT_EN
         if (k > 0) chk("wrap_data", data_out, {3{e}});
         tick();
`else
         tick();
         if (k > 0) chk("wrap_data", data_out, {3{e}});
`endif
      end
      push = 1'b0; pop = '0;
      chk("wrap_err", {ovf_err, udf_err}, 0);
      chk("wrap_cnt", count, 0);

      // inactive reader never stalls the writer
      clr = 1'b1; tick(); clr = 1'b0;
      act = 3'b011;
      for (int k = 0; k <= 20; k++) begin
         push = (k < 20);
         din  = 16'h0400 + 16'(k);
         pop  = (k > 0) ? 3'b011 : 3'b000;
         tick();
         chk("inact_nofull", full, 0);
      end
      push = 1'b0;
      pop = 3'b100; tick(); pop = '0;
      chk("inact_udf", udf_err, 3'b100);
      chk("inact_cnt2", count[14:10], 0);
      act = 3'b111; push = 1'b1; din = 16'h0ABC; tick(); push = 1'b0;
      chk("act_cnt", count, {3{5'd1}});
`ifdef FIFO_MR_ACT_FWFT_EN
      chk("act_first", data_out[47:32], 16'h0ABC);
`else
      pop = 3'b100; tick(); pop = '0;
      chk("act_first", data_out[47:32], 16'h0ABC);
`endif

      // reset and clear mid-operation
      for (int r = 0; r < 2; r++) begin
         clr = 1'b1; tick(); clr = 1'b0;
         push = 1'b1;
         for (int k = 0; k < 12; k++) begin din = 16'h0500 + 16'(k); tick(); end
         push = 1'b0;
         for (int k = 0; k < 9; k++) begin pop = {1'b0, 1'b1, k < 5}; tick(); end
         pop = '0;
         chk("mid_cnt", count, {5'd12, 5'd3, 5'd7});
         if (r == 0) begin
            rst_n = 1'b0; tick(); rst_n = 1'b1;
         end else begin
            clr = 1'b1; tick(); clr = 1'b0;
         end
         chk("mid_cnt0", count, 0);
         chk("mid_empty", empty, 3'b111);
         chk("mid_flags", {full, almost_full, ovf_err, udf_err}, 0);
         chk("mid_dout", data_out, 0);
         chk("mid_dval", data_valid, 0);
      end

`ifdef FIFO_MR_ACT_FWFT_EN
      push = 1'b1; din = 16'h1234; tick(); push = 1'b0;
      chk("fwft_show", data_out[15:0], 16'h1234);
      chk("fwft_dv", data_valid[0], 1);
`endif

      repeat (2) tick();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
